// File: rtl/ram_seq.sv
// ram_seq: single-port RAM access sequencer.
// Accepts one read or write request at a time through a valid/ready handshake
// and turns it into a one-cycle access on a downstream asynchronous-style RAM
// port. Each RAM access takes one cycle and is followed by one IDLE cycle, so
// at most one transaction is accepted every two cycles. After reset the
// sequencer can optionally sweep CLEAR_VALUE into every RAM location before it
// accepts any request.
// All outputs, including the RAM control and address lines, come straight from
// flops. The RAM data bus is driven only while a write strobe is low.
module ram_seq #(
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [7:0] CLEAR_VALUE    = 8'h00
) (
    input  logic       clk,
    input  logic       resetBar,
    input  logic       reqValid,
    output logic       reqReady,
    input  logic       reqWrite,
    input  logic [7:0] reqAddr,
    input  logic [7:0] reqData,
    output logic       rspValid,
    output logic [7:0] rspData,
    output logic       busy,
    output logic [7:0] ramAddr,
    output logic       ramOutputEnable,
    output logic       ramWriteEnableBar,
    inout  wire  [7:0] ramData
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_t;

    // Reset lands in CLEAR when a sweep is wanted, otherwise directly in IDLE.
    localparam state_t RESET_STATE = state_t'(CLEAR_ON_RESET ? S_CLEAR : S_IDLE);
    localparam logic   RESET_BUSY  = CLEAR_ON_RESET ? 1'b1 : 1'b0;

    // The RAM address, data and strobe flops double as the latched copy of
    // the accepted request. Later changes on req* therefore cannot disturb
    // an access that is already in flight.
    state_t     r_state;
    logic [7:0] r_counter;
    logic [7:0] r_ram_addr;
    logic       r_ram_oe;
    logic       r_ram_we_n;
    logic       r_ram_drive;
    logic [7:0] r_ram_dout;
    logic       r_req_ready;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;
    logic       r_busy;

    state_t     w_state_next;
    logic [7:0] w_counter_next;
    logic [7:0] w_ram_addr_next;
    logic       w_ram_oe_next;
    logic       w_ram_we_n_next;
    logic       w_ram_drive_next;
    logic [7:0] w_ram_dout_next;
    logic       w_req_ready_next;
    logic       w_rsp_valid_next;
    logic [7:0] w_rsp_data_next;
    logic       w_busy_next;
    logic       w_accept;

    // A request is accepted only while IDLE is presenting ready.
    assign w_accept = reqValid && r_req_ready && (r_state == S_IDLE);

    // Next-state logic and next values for every registered output.
    always_comb begin
        w_state_next     = r_state;
        w_counter_next   = r_counter;
        w_ram_addr_next  = r_ram_addr;
        w_ram_oe_next    = 1'b0;
        w_ram_we_n_next  = 1'b1;
        w_ram_drive_next = 1'b0;
        w_ram_dout_next  = r_ram_dout;
        w_req_ready_next = 1'b0;
        w_rsp_valid_next = 1'b0;
        w_rsp_data_next  = r_rsp_data;
        w_busy_next      = 1'b0;

        case (r_state)
            S_CLEAR: begin
                // While the write strobe is high, no sweep write has been
                // issued since reset. Address 0 is written first, and the
                // counter advances only after a write has been issued.
                if (!r_ram_we_n && (r_counter == 8'hFF)) begin
                    // Address 255 is being written now. Leave the sweep
                    // without wrapping back to address 0.
                    w_state_next     = S_IDLE;
                    w_req_ready_next = 1'b1;
                end else begin
                    if (!r_ram_we_n) begin
                        w_counter_next = r_counter + 8'd1;
                    end
                    w_state_next     = S_CLEAR;
                    w_busy_next      = 1'b1;
                    w_ram_addr_next  = w_counter_next;
                    w_ram_we_n_next  = 1'b0;
                    w_ram_drive_next = 1'b1;
                    w_ram_dout_next  = CLEAR_VALUE;
                end
            end
            S_IDLE: begin
                w_req_ready_next = 1'b1;
                if (w_accept) begin
                    w_req_ready_next = 1'b0;
                    w_ram_addr_next  = reqAddr;
                    if (reqWrite) begin
                        w_state_next     = S_WRITE;
                        w_ram_we_n_next  = 1'b0;
                        w_ram_drive_next = 1'b1;
                        w_ram_dout_next  = reqData;
                    end else begin
                        w_state_next  = S_READ;
                        w_ram_oe_next = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                w_state_next     = S_IDLE;
                w_req_ready_next = 1'b1;
            end
            S_READ: begin
                // The RAM drives the bus during READ. Its value is captured
                // on the edge that ends READ.
                w_state_next     = S_IDLE;
                w_req_ready_next = 1'b1;
                w_rsp_valid_next = 1'b1;
                w_rsp_data_next  = ramData;
            end
            default: begin
                w_state_next     = S_IDLE;
                w_req_ready_next = 1'b1;
            end
        endcase
    end

    // State and output registers. Reset immediately parks the RAM port in a
    // safe state, so an access that is in progress is aborted.
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            r_state     <= RESET_STATE;
            r_counter   <= 8'h00;
            r_ram_addr  <= 8'h00;
            r_ram_oe    <= 1'b0;
            r_ram_we_n  <= 1'b1;
            r_ram_drive <= 1'b0;
            r_ram_dout  <= 8'h00;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_busy      <= RESET_BUSY;
        end else begin
            r_state     <= w_state_next;
            r_counter   <= w_counter_next;
            r_ram_addr  <= w_ram_addr_next;
            r_ram_oe    <= w_ram_oe_next;
            r_ram_we_n  <= w_ram_we_n_next;
            r_ram_drive <= w_ram_drive_next;
            r_ram_dout  <= w_ram_dout_next;
            r_req_ready <= w_req_ready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_data  <= w_rsp_data_next;
            r_busy      <= w_busy_next;
        end
    end

    assign reqReady          = r_req_ready;
    assign rspValid          = r_rsp_valid;
    assign rspData           = r_rsp_data;
    assign busy              = r_busy;
    assign ramAddr           = r_ram_addr;
    assign ramOutputEnable   = r_ram_oe;
    assign ramWriteEnableBar = r_ram_we_n;
    // The drive enable is set only together with a write strobe and never
    // together with the output enable, so the bus cannot be contended.
    assign ramData           = r_ram_drive ? r_ram_dout : 8'hzz;

endmodule
